// File: rtl/sram_port_ctrl_pkg.sv
// Shared types and default sizing for the SRAM port controller.
// The defaults match the sram1024x18 macro.
package sram_port_ctrl_pkg;

    localparam int DEF_ADDR_W    = 10;
    localparam int DEF_DATA_W    = 18;
    localparam int DEF_RSP_DEPTH = 4;

    typedef enum logic {
        SCRUB = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/sram_port_ctrl_rsp_fifo.sv
// Read-response FIFO for the SRAM port controller. Zero-latency head (pop_data valid while !empty).
// Upstream is expected never to push when full; a push-when-full is dropped and flagged by an assertion.
module sram_port_ctrl_rsp_fifo #(
    parameter  int DATA_W = 18,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              full;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Head is forced to zero when empty so rsp_rdata reads zero out of reset.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/sram_port_ctrl.sv
// Valid/ready initiator for one sram1024x18 port; reads return 2 cycles after accept, in order.
// Credits (FIFO count + reads in flight) gate req_ready so rsp backpressure never drops data.
// Define SRAM_PORT_CTRL_SCRUB_EN to zero the whole array after every reset before accepting requests.
module sram_port_ctrl
    import sram_port_ctrl_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int RSP_DEPTH = DEF_RSP_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_be,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              sram_cen,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wmsk,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    state_t            state;
    logic [ADDR_W-1:0] scrub_addr;
    logic              p1;
    logic              p2;
    logic [CNT_W-1:0]  rsp_count;
    logic [CNT_W:0]    outstanding;
    logic              fifo_empty;
    logic              accept;

    // Every read holds a FIFO slot from acceptance until the consumer pops it.
    assign outstanding = (CNT_W+1)'(rsp_count) + (CNT_W+1)'(p1) + (CNT_W+1)'(p2);
    assign req_ready   = !rst && (state == RUN) && (outstanding < (CNT_W+1)'(RSP_DEPTH));
    assign accept      = req_valid && req_ready;
    assign rsp_valid   = !fifo_empty;

`ifdef SRAM_PORT_CTRL_SCRUB_EN
    assign busy = (state == SCRUB);
`else
    assign busy = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
`ifdef SRAM_PORT_CTRL_SCRUB_EN
            state <= SCRUB;
`else
            state <= RUN;
`endif
            scrub_addr <= '0;
            sram_cen   <= 1'b1;
            sram_wen   <= 1'b1;
            sram_addr  <= '0;
            sram_wmsk  <= '1;
            sram_wdata <= '0;
            p1         <= 1'b0;
            p2         <= 1'b0;
        end else begin
            p2       <= p1;
            p1       <= 1'b0;
            sram_cen <= 1'b1;
            sram_wen <= 1'b1;
            case (state)
                SCRUB: begin
                    sram_cen   <= 1'b0;
                    sram_wen   <= 1'b0;
                    sram_addr  <= scrub_addr;
                    sram_wmsk  <= '0;
                    sram_wdata <= '0;
                    scrub_addr <= scrub_addr + 1'b1;
                    if (scrub_addr == '1) state <= RUN;
                end
                default: begin
                    if (accept) begin
                        sram_cen  <= 1'b0;
                        sram_wen  <= !req_we;
                        sram_addr <= req_addr;
                        sram_wmsk <= req_we ? ~req_be : '1;
                        if (req_we) sram_wdata <= req_wdata;
                        p1 <= !req_we;
                    end
                end
            endcase
        end
    end

    // p2 marks the cycle the macro drives the word latched one edge earlier.
    sram_port_ctrl_rsp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (p2),
        .push_data (sram_rdata),
        .pop       (rsp_ready),
        .pop_data  (rsp_rdata),
        .empty     (fifo_empty),
        .count     (rsp_count)
    );

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Bench for sram_port_ctrl: macro model, per-cycle reference comparison, directed and random traffic.
module tb_sram_port_ctrl;

    localparam int AW    = 10;
    localparam int DW    = 18;
    localparam int DEPTH = 4;
    localparam int WORDS = 1 << AW;
`ifdef SRAM_PORT_CTRL_SCRUB_EN
    localparam int SCRUB_WORDS = WORDS;
`else
    localparam int SCRUB_WORDS = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_be, req_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          busy, sram_cen, sram_wen;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wmsk, sram_wdata;
    logic [DW-1:0] sram_rdata = '0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [DW-1:0] d;
        int            avail;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] ref_mem [WORDS];
    logic [DW-1:0] sram_mem [WORDS];
    int            acc_n[$];
    int            pop_n[$];
    logic [DW-1:0] pop_d[$];
    int            nidx = 0;

    always #5 clk = ~clk;

    sram_port_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_be     (req_be),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .busy       (busy),
        .sram_cen   (sram_cen),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wmsk  (sram_wmsk),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        logic [31:0] h;
        h = 32'(i) * 32'h9E3779B1;
        return h[DW+3:4];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Macro: inputs latched on the rising edge, read word driven until the next read.
    initial begin : macro
        for (int i = 0; i < WORDS; i++) sram_mem[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (!sram_cen) begin
                if (!sram_wen)
                    sram_mem[sram_addr] = (sram_mem[sram_addr] & sram_wmsk) | (sram_wdata & ~sram_wmsk);
                else
                    sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    // Reference: memory image plus queue of reads owed, each visible from a given sample index.
    initial begin : model
        logic          e_cen, e_wen, e_valid;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wmsk, e_wdata;
        int            scrub_left;
        e_cen = 1'b1; e_wen = 1'b1; e_addr = '0; e_wmsk = '1; e_wdata = '0;
        scrub_left = SCRUB_WORDS;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = init_val(i);
        forever begin
            @(negedge clk);
            nidx++;
            if (rst) begin
                exp_q.delete();
                e_cen = 1'b1; e_wen = 1'b1; e_addr = '0; e_wmsk = '1; e_wdata = '0;
                scrub_left = SCRUB_WORDS;
                chk("rst_req_ready", 32'(req_ready), 32'(0));
                chk("rst_busy", 32'(busy), 32'(SCRUB_WORDS != 0));
                chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
                chk("rst_rsp_rdata", 32'(rsp_rdata), 32'(0));
                chk("rst_cen", 32'(sram_cen), 32'(1));
                chk("rst_wen", 32'(sram_wen), 32'(1));
                chk("rst_addr", 32'(sram_addr), 32'(0));
                chk("rst_wmsk", 32'(sram_wmsk), 32'h3FFFF);
                chk("rst_wdata", 32'(sram_wdata), 32'(0));
            end else begin
                e_valid = (exp_q.size() > 0) && (exp_q[0].avail <= nidx);
                chk("busy", 32'(busy), 32'(scrub_left != 0));
                chk("req_ready", 32'(req_ready), 32'((scrub_left == 0) && (exp_q.size() < DEPTH)));
                chk("rsp_valid", 32'(rsp_valid), 32'(e_valid));
                if (e_valid) chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_q[0].d));
                chk("sram_cen", 32'(sram_cen), 32'(e_cen));
                chk("sram_wen", 32'(sram_wen), 32'(e_wen));
                chk("sram_addr", 32'(sram_addr), 32'(e_addr));
                chk("sram_wmsk", 32'(sram_wmsk), 32'(e_wmsk));
                chk("sram_wdata", 32'(sram_wdata), 32'(e_wdata));
                if (rsp_valid && rsp_ready) begin
                    pop_n.push_back(nidx);
                    pop_d.push_back(rsp_rdata);
                end
                if (e_valid && rsp_ready) void'(exp_q.pop_front());
                if (scrub_left != 0) begin
                    e_cen = 1'b0; e_wen = 1'b0; e_wmsk = '0; e_wdata = '0;
                    e_addr = AW'(WORDS - scrub_left);
                    ref_mem[e_addr] = '0;
                    scrub_left--;
                end else if (req_valid && req_ready) begin
                    acc_n.push_back(nidx);
                    e_cen  = 1'b0;
                    e_addr = req_addr;
                    if (req_we) begin
                        e_wen   = 1'b0;
                        e_wmsk  = ~req_be;
                        e_wdata = req_wdata;
                        ref_mem[req_addr] = (ref_mem[req_addr] & ~req_be) | (req_wdata & req_be);
                    end else begin
                        e_wen  = 1'b1;
                        e_wmsk = '1;
                        exp_q.push_back('{ref_mem[req_addr], nidx + 3});
                    end
                end else begin
                    e_cen = 1'b1;
                    e_wen = 1'b1;
                end
            end
        end
    end

    task automatic clear_logs();
        acc_n.delete();
        pop_n.delete();
        pop_d.delete();
    endtask

    task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] be,
                        input logic [DW-1:0] wd);
        int t;
        req_valid = 1'b1; req_we = we; req_addr = a; req_be = be; req_wdata = wd;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("send_accepted", 32'(req_ready), 32'(1));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_pops(input int k);
        int t;
        t = 0;
        while (pop_n.size() < k && t < 60) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("pop_count", 32'(pop_n.size()), 32'(k));
    endtask

    task automatic wait_idle_after_reset();
`ifdef SRAM_PORT_CTRL_SCRUB_EN
        int n;
        n = 0;
        while (busy && n < 1100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("scrub_cycles", 32'(n), 32'(1024));
        clear_logs();
        send(1'b0, 10'h3FF, '0, '0);
        wait_pops(1);
        if (pop_d.size() > 0) chk("scrubbed_word", 32'(pop_d[0]), 32'h00000);
`else
        @(posedge clk);
        #1;
        chk("busy_idle", 32'(busy), 32'(0));
`endif
    endtask

    initial begin : drive
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_be = '0; req_wdata = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        wait_idle_after_reset();

        // Full write then read-back, with read latency pinned.
        clear_logs();
        send(1'b1, 10'h005, '1, 18'h2A5A5);
        send(1'b0, 10'h005, '0, '0);
        wait_pops(1);
        if (pop_d.size() > 0 && acc_n.size() > 1) begin
            chk("rd_after_wr", 32'(pop_d[0]), 32'h2A5A5);
            chk("rd_latency_edges", 32'(pop_n[0] - acc_n[1] - 1), 32'(2));
        end

        // Partial write keeps the unmasked upper bits.
        clear_logs();
        send(1'b1, 10'h010, '1, 18'h3FFFF);
        send(1'b1, 10'h010, 18'h000FF, 18'h00000);
        send(1'b0, 10'h010, '0, '0);
        wait_pops(1);
        if (pop_d.size() > 0) chk("masked_write", 32'(pop_d[0]), 32'h3FF00);

        // Back-to-back reads: one accept per cycle and bubble-free responses.
        clear_logs();
        for (int a = 1; a <= 8; a++) send(1'b0, AW'(a), '0, '0);
        wait_pops(8);
        if (pop_n.size() == 8 && acc_n.size() == 8) begin
            chk("b2b_accept_span", 32'(acc_n[7] - acc_n[0]), 32'(7));
            chk("b2b_rsp_span", 32'(pop_n[7] - pop_n[0]), 32'(7));
        end

        // Stalled consumer: credits run out after DEPTH reads.
        clear_logs();
        rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            req_addr = AW'($urandom);
            @(posedge clk);
            #1;
        end
        chk("credit_accepts", 32'(acc_n.size()), 32'(4));
        chk("credit_ready_low", 32'(req_ready), 32'(0));
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_pops(4);
        if (pop_n.size() == 4) chk("drain_span", 32'(pop_n[3] - pop_n[0]), 32'(3));
        @(posedge clk);
        #1;
        chk("ready_back", 32'(req_ready), 32'(1));

        // Reset with reads in flight.
        clear_logs();
        send(1'b0, 10'h020, '0, '0);
        send(1'b0, 10'h021, '0, '0);
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("midrst_cen", 32'(sram_cen), 32'(1));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wait_idle_after_reset();
        clear_logs();
        repeat (10) @(posedge clk);
        #1;
        chk("no_stale_rsp", 32'(pop_n.size()), 32'(0));

        // Random mix on a small address window so reads hit recent writes.
        for (int i = 0; i < 600; i++) begin
            req_valid = ($urandom_range(0, 99) < 60);
            req_we    = ($urandom_range(0, 2) == 0);
            req_addr  = AW'($urandom_range(0, 15));
            req_be    = DW'($urandom);
            req_wdata = DW'($urandom);
            rsp_ready = ($urandom_range(0, 99) < 70);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("final_idle", 32'(rsp_valid), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
